// File: rtl/core_mem_pkg.sv
// Shared types and defaults for the core memory arbiter.
// The optional starvation guard is enabled by defining CORE_ARB_STARVE_EN.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    // Consecutive D grants tolerated while I waits (starvation guard builds only)
    localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Fetch, load/store and memory-bus signals of the core memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding core and bus.
interface core_mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              i_req_valid;
    logic              i_req_ready;
    logic [AW-1:0]     i_addr;
    logic              i_kill;
    logic              i_resp_valid;
    logic [DW-1:0]     i_resp_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [AW-1:0]     d_addr;
    logic              d_wen;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_wstrb;
    logic              d_resp_valid;
    logic [DW-1:0]     d_resp_rdata;

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [AW-1:0]     bus_addr;
    logic              bus_wen;
    logic [DW-1:0]     bus_wdata;
    logic [DW/8-1:0]   bus_wstrb;
    logic              bus_resp_valid;
    logic [DW-1:0]     bus_resp_rdata;

    modport slave (
        input  i_req_valid, i_addr, i_kill,
        output i_req_ready, i_resp_valid, i_resp_rdata,
        input  d_req_valid, d_addr, d_wen, d_wdata, d_wstrb,
        output d_req_ready, d_resp_valid, d_resp_rdata,
        output bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata
    );

    modport master (
        output i_req_valid, i_addr, i_kill,
        input  i_req_ready, i_resp_valid, i_resp_rdata,
        output d_req_valid, d_addr, d_wen, d_wdata, d_wstrb,
        input  d_req_ready, d_resp_valid, d_resp_rdata,
        input  bus_req_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata
    );

endinterface

// File: rtl/core_arb_grant.sv
// Grant selection for the memory arbiter: D wins over I, since it is older in program order.
// With CORE_ARB_STARVE_EN defined, a saturating counter forces an I grant after
// STARVE_MAX consecutive D grants taken while I was waiting.
module core_arb_grant
    import core_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    input  logic d_valid,
    input  logic idle,
    output logic grant_i,
    output logic grant_d
);

`ifdef CORE_ARB_STARVE_EN
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          force_i;

    assign force_i = (starve_q == CW'(STARVE_MAX));

    // Priority select with the starvation override, plus counter next state
    always_comb begin
        grant_d  = idle && d_valid && !(force_i && i_valid);
        grant_i  = idle && i_valid && !grant_d;
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d && i_valid && !force_i) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_in;

    assign unused_in = clk ^ rst_n ^ (STARVE_MAX == 0);

    // Strict D priority
    always_comb begin
        grant_d = idle && d_valid;
        grant_i = idle && i_valid && !d_valid;
    end
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory bus between the fetch (I) and memory (D) stages.
// One transaction outstanding: IDLE grants and latches, REQ drives the bus, RESP routes back.
// A redirect (i_kill) during an I transaction swallows its response.
// Optional starvation guard: define CORE_ARB_STARVE_EN.
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    core_mem_arbiter_if.slave mem
);

    arb_state_t      state_q, state_d;
    arb_owner_t      owner_q, owner_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic            kill_pend_q, kill_pend_d;
    logic            grant_i, grant_d;
    logic            resp_hit;

    core_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (mem.i_req_valid),
        .d_valid (mem.d_req_valid),
        .idle    (state_q == IDLE),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // Next state: latch the granted request in IDLE, track bus handshakes and kill
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        kill_pend_d = kill_pend_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d = OWN_D;
                    addr_d  = mem.d_addr;
                    wen_d   = mem.d_wen;
                    wdata_d = mem.d_wdata;
                    wstrb_d = mem.d_wstrb;
                    state_d = REQ;
                end else if (grant_i) begin
                    owner_d = OWN_I;
                    addr_d  = mem.i_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem.bus_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem.bus_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A kill only matters for a fetch already on its way; IDLE forgets it
        if (state_d == IDLE) begin
            kill_pend_d = 1'b0;
        end else if (state_q != IDLE && owner_q == OWN_I && mem.i_kill) begin
            kill_pend_d = 1'b1;
        end
    end

    // State and request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            kill_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            kill_pend_q <= kill_pend_d;
        end
    end

    // Outputs: ready on grant, bus from registers, response routed to its owner
    always_comb begin
        resp_hit         = (state_q == RESP) && mem.bus_resp_valid;
        mem.i_req_ready  = grant_i;
        mem.d_req_ready  = grant_d;
        mem.bus_req_valid = (state_q == REQ);
        mem.bus_addr     = addr_q;
        mem.bus_wen      = wen_q;
        mem.bus_wdata    = wdata_q;
        mem.bus_wstrb    = wstrb_q;
        mem.i_resp_valid = resp_hit && owner_q == OWN_I && !kill_pend_q && !mem.i_kill;
        mem.d_resp_valid = resp_hit && owner_q == OWN_D;
        mem.i_resp_rdata = mem.bus_resp_rdata;
        mem.d_resp_rdata = mem.bus_resp_rdata;
    end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: reset, fetch, priority, stall, kill,
// starvation sequence and asynchronous reset mid-transaction.
module tb_core_mem_arbiter;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    core_mem_arbiter_if #(.AW(32), .DW(32)) mem_if ();

    core_mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        mem_if.i_req_valid    = 1'b0;
        mem_if.i_addr         = '0;
        mem_if.i_kill         = 1'b0;
        mem_if.d_req_valid    = 1'b0;
        mem_if.d_addr         = '0;
        mem_if.d_wen          = 1'b0;
        mem_if.d_wdata        = '0;
        mem_if.d_wstrb        = '0;
        mem_if.bus_req_ready  = 1'b0;
        mem_if.bus_resp_valid = 1'b0;
        mem_if.bus_resp_rdata = '0;
    endtask

    // Drives a granted transaction through REQ and RESP; ends at a negedge in IDLE
    task automatic finish_txn(input logic [31:0] rdata, input bit keep);
        @(negedge clk);
        if (!keep) begin
            mem_if.i_req_valid = 1'b0;
            mem_if.d_req_valid = 1'b0;
        end
        mem_if.bus_req_ready = 1'b1;
        @(negedge clk);
        mem_if.bus_req_ready  = 1'b0;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b1;
        mem_if.bus_resp_rdata = rdata;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_total++; if (mem_if.i_req_ready !== 1'b0) $display("FAIL reset_i_ready got %b exp 0", mem_if.i_req_ready); else n_pass++;
        n_total++; if (mem_if.d_req_ready !== 1'b0) $display("FAIL reset_d_ready got %b exp 0", mem_if.d_req_ready); else n_pass++;
        n_total++; if (mem_if.bus_req_valid !== 1'b0) $display("FAIL reset_bus_valid got %b exp 0", mem_if.bus_req_valid); else n_pass++;
        n_total++; if (mem_if.bus_addr !== 32'h0) $display("FAIL reset_bus_addr got %h exp 0", mem_if.bus_addr); else n_pass++;
        n_total++; if (mem_if.i_resp_valid !== 1'b0 || mem_if.d_resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b%b exp 00", mem_if.i_resp_valid, mem_if.d_resp_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_i_only();
        @(negedge clk);
        mem_if.i_req_valid = 1'b1;
        mem_if.i_addr      = 32'h100;
        #1;
        n_total++; if (mem_if.i_req_ready !== 1'b1) $display("FAIL ionly_c0_ready got %b exp 1", mem_if.i_req_ready); else n_pass++;
        n_total++; if (mem_if.bus_req_valid !== 1'b0) $display("FAIL ionly_c0_bus_valid got %b exp 0", mem_if.bus_req_valid); else n_pass++;
        @(negedge clk);
        mem_if.i_req_valid   = 1'b0;
        mem_if.bus_req_ready = 1'b1;
        #1;
        n_total++; if (mem_if.bus_req_valid !== 1'b1) $display("FAIL ionly_c1_bus_valid got %b exp 1", mem_if.bus_req_valid); else n_pass++;
        n_total++; if (mem_if.bus_addr !== 32'h100) $display("FAIL ionly_c1_addr got %h exp 00000100", mem_if.bus_addr); else n_pass++;
        n_total++; if (mem_if.bus_wen !== 1'b0 || mem_if.bus_wstrb !== 4'h0) $display("FAIL ionly_c1_wen_wstrb got %b/%h exp 0/0", mem_if.bus_wen, mem_if.bus_wstrb); else n_pass++;
        @(negedge clk);
        mem_if.bus_req_ready = 1'b0;
        #1;
        n_total++; if (mem_if.bus_req_valid !== 1'b0) $display("FAIL ionly_c2_bus_valid got %b exp 0", mem_if.bus_req_valid); else n_pass++;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b1;
        mem_if.bus_resp_rdata = 32'hDEADBEEF;
        #1;
        n_total++; if (mem_if.i_resp_valid !== 1'b1) $display("FAIL ionly_c3_resp_valid got %b exp 1", mem_if.i_resp_valid); else n_pass++;
        n_total++; if (mem_if.i_resp_rdata !== 32'hDEADBEEF) $display("FAIL ionly_c3_rdata got %h exp deadbeef", mem_if.i_resp_rdata); else n_pass++;
        n_total++; if (mem_if.d_resp_valid !== 1'b0) $display("FAIL ionly_c3_d_resp got %b exp 0", mem_if.d_resp_valid); else n_pass++;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b0;
        #1;
        n_total++; if (mem_if.i_resp_valid !== 1'b0) $display("FAIL ionly_c4_resp_valid got %b exp 0", mem_if.i_resp_valid); else n_pass++;
    endtask

    task automatic test_priority();
        @(negedge clk);
        mem_if.i_req_valid = 1'b1;
        mem_if.i_addr      = 32'h300;
        mem_if.d_req_valid = 1'b1;
        mem_if.d_addr      = 32'h200;
        mem_if.d_wen       = 1'b1;
        mem_if.d_wdata     = 32'h55;
        mem_if.d_wstrb     = 4'h1;
        #1;
        n_total++; if (mem_if.d_req_ready !== 1'b1 || mem_if.i_req_ready !== 1'b0) $display("FAIL prio_grant got d%b i%b exp d1 i0", mem_if.d_req_ready, mem_if.i_req_ready); else n_pass++;
        @(negedge clk);
        mem_if.d_req_valid   = 1'b0;
        mem_if.bus_req_ready = 1'b1;
        #1;
        n_total++; if (mem_if.bus_addr !== 32'h200 || mem_if.bus_wdata !== 32'h55) $display("FAIL prio_bus_fields got %h/%h exp 00000200/00000055", mem_if.bus_addr, mem_if.bus_wdata); else n_pass++;
        n_total++; if (mem_if.bus_wen !== 1'b1 || mem_if.bus_wstrb !== 4'h1) $display("FAIL prio_wen_wstrb got %b/%h exp 1/1", mem_if.bus_wen, mem_if.bus_wstrb); else n_pass++;
        n_total++; if (mem_if.i_req_ready !== 1'b0) $display("FAIL prio_no_grant_req got %b exp 0", mem_if.i_req_ready); else n_pass++;
        @(negedge clk);
        mem_if.bus_req_ready = 1'b0;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b1;
        mem_if.bus_resp_rdata = 32'h0;
        #1;
        n_total++; if (mem_if.d_resp_valid !== 1'b1 || mem_if.i_resp_valid !== 1'b0) $display("FAIL prio_d_resp got d%b i%b exp d1 i0", mem_if.d_resp_valid, mem_if.i_resp_valid); else n_pass++;
        n_total++; if (mem_if.i_req_ready !== 1'b0) $display("FAIL prio_no_grant_resp got %b exp 0", mem_if.i_req_ready); else n_pass++;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b0;
        #1;
        n_total++; if (mem_if.i_req_ready !== 1'b1) $display("FAIL prio_i_after got %b exp 1", mem_if.i_req_ready); else n_pass++;
        @(negedge clk);
        mem_if.i_req_valid   = 1'b0;
        mem_if.bus_req_ready = 1'b1;
        #1;
        n_total++; if (mem_if.bus_addr !== 32'h300 || mem_if.bus_wstrb !== 4'h0) $display("FAIL prio_i_fields got %h/%h exp 00000300/0", mem_if.bus_addr, mem_if.bus_wstrb); else n_pass++;
        @(negedge clk);
        mem_if.bus_req_ready = 1'b0;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b1;
        mem_if.bus_resp_rdata = 32'hCAFE0001;
        #1;
        n_total++; if (mem_if.i_resp_valid !== 1'b1 || mem_if.i_resp_rdata !== 32'hCAFE0001) $display("FAIL prio_i_resp got %b/%h exp 1/cafe0001", mem_if.i_resp_valid, mem_if.i_resp_rdata); else n_pass++;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b0;
        mem_if.d_wen          = 1'b0;
        mem_if.d_wstrb        = 4'h0;
    endtask

    task automatic test_stall();
        @(negedge clk);
        mem_if.d_req_valid = 1'b1;
        mem_if.d_addr      = 32'h404;
        mem_if.i_req_valid = 1'b1;
        mem_if.i_addr      = 32'h500;
        #1;
        n_total++; if (mem_if.d_req_ready !== 1'b1) $display("FAIL stall_grant got %b exp 1", mem_if.d_req_ready); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mem_if.d_req_valid    = 1'b0;
            mem_if.bus_resp_valid = (k == 2);
            mem_if.bus_resp_rdata = 32'hBAD0BAD0;
            #1;
            n_total++; if (mem_if.bus_req_valid !== 1'b1 || mem_if.bus_addr !== 32'h404) $display("FAIL stall_hold_%0d got %b/%h exp 1/00000404", k, mem_if.bus_req_valid, mem_if.bus_addr); else n_pass++;
            n_total++; if (mem_if.i_req_ready !== 1'b0 || mem_if.d_resp_valid !== 1'b0) $display("FAIL stall_quiet_%0d got ready %b resp %b exp 0 0", k, mem_if.i_req_ready, mem_if.d_resp_valid); else n_pass++;
        end
        mem_if.bus_resp_valid = 1'b0;
        finish_txn(32'h77, 1'b1);
        #1;
        n_total++; if (mem_if.i_req_ready !== 1'b1) $display("FAIL stall_i_next got %b exp 1", mem_if.i_req_ready); else n_pass++;
        finish_txn(32'h88, 1'b0);
    endtask

    task automatic test_kill();
        @(negedge clk);
        mem_if.i_req_valid = 1'b1;
        mem_if.i_addr      = 32'h600;
        @(negedge clk);
        mem_if.i_req_valid   = 1'b0;
        mem_if.bus_req_ready = 1'b1;
        @(negedge clk);
        mem_if.bus_req_ready = 1'b0;
        mem_if.i_kill        = 1'b1;
        @(negedge clk);
        mem_if.i_kill         = 1'b0;
        mem_if.bus_resp_valid = 1'b1;
        mem_if.bus_resp_rdata = 32'h1234;
        #1;
        n_total++; if (mem_if.i_resp_valid !== 1'b0 || mem_if.d_resp_valid !== 1'b0) $display("FAIL kill_suppress got i%b d%b exp 0 0", mem_if.i_resp_valid, mem_if.d_resp_valid); else n_pass++;
        // Next fetch, with a kill in IDLE that must be ignored
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b0;
        mem_if.i_req_valid    = 1'b1;
        mem_if.i_addr         = 32'h700;
        mem_if.i_kill         = 1'b1;
        #1;
        n_total++; if (mem_if.bus_req_valid !== 1'b0 || mem_if.i_req_ready !== 1'b1) $display("FAIL kill_idle got bus %b ready %b exp 0 1", mem_if.bus_req_valid, mem_if.i_req_ready); else n_pass++;
        @(negedge clk);
        mem_if.i_kill = 1'b0;
        #1;
        n_total++; if (mem_if.bus_addr !== 32'h700) $display("FAIL kill_next_addr got %h exp 00000700", mem_if.bus_addr); else n_pass++;
        finish_txn(32'hABCD, 1'b0);
        n_total++; if (mem_if.i_resp_valid !== 1'b0) $display("FAIL kill_next_after got %b exp 0", mem_if.i_resp_valid); else n_pass++;
        // Third fetch: kill coinciding with the response
        @(negedge clk);
        mem_if.i_req_valid = 1'b1;
        mem_if.i_addr      = 32'h704;
        @(negedge clk);
        mem_if.i_req_valid   = 1'b0;
        mem_if.bus_req_ready = 1'b1;
        @(negedge clk);
        mem_if.bus_req_ready = 1'b0;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b1;
        mem_if.bus_resp_rdata = 32'h5678;
        mem_if.i_kill         = 1'b1;
        #1;
        n_total++; if (mem_if.i_resp_valid !== 1'b0) $display("FAIL kill_coincide got %b exp 0", mem_if.i_resp_valid); else n_pass++;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b0;
        mem_if.i_kill         = 1'b0;
        // Fourth fetch served normally
        mem_if.i_req_valid    = 1'b1;
        mem_if.i_addr         = 32'h708;
        @(negedge clk);
        mem_if.i_req_valid   = 1'b0;
        mem_if.bus_req_ready = 1'b1;
        @(negedge clk);
        mem_if.bus_req_ready = 1'b0;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b1;
        mem_if.bus_resp_rdata = 32'h9ABC;
        #1;
        n_total++; if (mem_if.i_resp_valid !== 1'b1 || mem_if.i_resp_rdata !== 32'h9ABC) $display("FAIL kill_recover got %b/%h exp 1/00009abc", mem_if.i_resp_valid, mem_if.i_resp_rdata); else n_pass++;
        @(negedge clk);
        mem_if.bus_resp_valid = 1'b0;
    endtask

    // Both requesters valid continuously; expects D,D,D,D,I,D with the guard, D only without
    task automatic test_starve(input string tag);
        logic [5:0] seq;
`ifdef CORE_ARB_STARVE_EN
        seq = 6'b101111;
`else
        seq = 6'b111111;
`endif
        @(negedge clk);
        mem_if.i_req_valid = 1'b1;
        mem_if.i_addr      = 32'hA00;
        mem_if.d_req_valid = 1'b1;
        mem_if.d_addr      = 32'hB00;
        for (int g = 0; g < 6; g++) begin
            #1;
            n_total++; if (mem_if.d_req_ready !== seq[g] || mem_if.i_req_ready !== !seq[g]) $display("FAIL %s_grant_%0d got d%b i%b exp d%b i%b", tag, g, mem_if.d_req_ready, mem_if.i_req_ready, seq[g], !seq[g]); else n_pass++;
            finish_txn(32'h0, 1'b1);
        end
        mem_if.i_req_valid = 1'b0;
        mem_if.d_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_if.i_req_valid = 1'b1;
        mem_if.i_addr      = 32'h900;
        mem_if.d_req_valid = 1'b1;
        mem_if.d_addr      = 32'h800;
        #1;
        n_total++; if (mem_if.d_req_ready !== 1'b1) $display("FAIL rstmid_grant got %b exp 1", mem_if.d_req_ready); else n_pass++;
        @(negedge clk);
        mem_if.d_req_valid = 1'b0;
        #1;
        n_total++; if (mem_if.bus_req_valid !== 1'b1) $display("FAIL rstmid_req got %b exp 1", mem_if.bus_req_valid); else n_pass++;
        #2;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        n_total++; if (mem_if.bus_req_valid !== 1'b0 || mem_if.bus_addr !== 32'h0) $display("FAIL rstmid_async got %b/%h exp 0/00000000", mem_if.bus_req_valid, mem_if.bus_addr); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        test_starve("rstmid");
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_i_only();
        test_priority();
        test_stall();
        test_kill();
        test_starve("starve");
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
